// File: rtl/tk1_udi_pkg.sv
// Shared constants, FSM encoding and address decode for the TK1 UDI fetch block.
package tk1_udi_pkg;

  localparam logic [7:0] UDI_ADDR_FIRST_DEF  = 8'h30;
  localparam logic [7:0] UDI_ADDR_LAST_DEF   = 8'h31;
  localparam logic [7:0] UDI_ADDR_STATUS_DEF = 8'h32;
  localparam logic [7:0] UDI_ADDR_LOCK_DEF   = 8'h33;

  typedef enum logic [1:0] {
    FETCH0 = 2'd0,
    FETCH1 = 2'd1,
    DONE   = 2'd2
  } fetch_state_t;

  typedef enum logic [2:0] {
    ACC_NONE   = 3'd0,
    ACC_WORD0  = 3'd1,
    ACC_WORD1  = 3'd2,
    ACC_STATUS = 3'd3,
    ACC_LOCK   = 3'd4
  } acc_kind_t;

  function automatic acc_kind_t decode_addr(
    input logic [7:0] addr,
    input logic [7:0] a_first,
    input logic [7:0] a_last,
    input logic [7:0] a_status,
    input logic [7:0] a_lock
  );
    acc_kind_t kind;
    kind = ACC_NONE;
    if (addr == a_first)       kind = ACC_WORD0;
    else if (addr == a_last)   kind = ACC_WORD1;
    else if (addr == a_status) kind = ACC_STATUS;
    else if (addr == a_lock)   kind = ACC_LOCK;
    return kind;
  endfunction

endpackage

// File: rtl/udi_fetch_bus.sv
// Bus access side of the UDI fetch block: read mux, lock register, ready and
// access-violation pulses.
module udi_fetch_bus
  import tk1_udi_pkg::*;
#(
  parameter logic [7:0] ADDR_UDI_FIRST  = UDI_ADDR_FIRST_DEF,
  parameter logic [7:0] ADDR_UDI_LAST   = UDI_ADDR_LAST_DEF,
  parameter logic [7:0] ADDR_UDI_STATUS = UDI_ADDR_STATUS_DEF,
  parameter logic [7:0] ADDR_UDI_LOCK   = UDI_ADDR_LOCK_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fw_app_mode,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic        udi_valid,
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        access_violation,
  output logic        locked
);

  acc_kind_t kind;
  logic      denied;

  assign kind   = decode_addr(address, ADDR_UDI_FIRST, ADDR_UDI_LAST,
                              ADDR_UDI_STATUS, ADDR_UDI_LOCK);
  // UDI words are hidden from applications and after lock; not-yet-valid is
  // merely empty, not a violation.
  assign denied = fw_app_mode | locked;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      read_data        <= 32'h0;
      ready            <= 1'b0;
      access_violation <= 1'b0;
      locked           <= 1'b0;
    end else begin
      ready            <= cs;
      access_violation <= 1'b0;
      if (cs) begin
        read_data <= 32'h0;
        if (!we) begin
          case (kind)
            ACC_WORD0: begin
              if (denied)         access_violation <= 1'b1;
              else if (udi_valid) read_data        <= word0;
            end
            ACC_WORD1: begin
              if (denied)         access_violation <= 1'b1;
              else if (udi_valid) read_data        <= word1;
            end
            ACC_STATUS: read_data <= {30'h0, locked, udi_valid};
            default:    read_data <= 32'h0;
          endcase
        end else if (kind == ACC_LOCK) begin
          if (fw_app_mode) access_violation <= 1'b1;
          else             locked           <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/udi_fetch.sv
// Fetches the two UDI words from the sibling ROM after reset and serves them
// to firmware over the register bus until locked.
module udi_fetch
  import tk1_udi_pkg::*;
#(
  parameter logic [7:0] ADDR_UDI_FIRST  = UDI_ADDR_FIRST_DEF,
  parameter logic [7:0] ADDR_UDI_LAST   = UDI_ADDR_LAST_DEF,
  parameter logic [7:0] ADDR_UDI_STATUS = UDI_ADDR_STATUS_DEF,
  parameter logic [7:0] ADDR_UDI_LOCK   = UDI_ADDR_LOCK_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fw_app_mode,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        udi_addr,
  input  logic [31:0] udi_data,
  output logic        udi_valid,
  output logic        access_violation
);

  fetch_state_t state;
  logic [31:0]  word0;
  logic [31:0]  word1;
  logic         locked;
  logic         unused_write_data;

  // The lock register is a pure strobe; its data is deliberately discarded.
  assign unused_write_data = ^write_data;

  // udi_addr is registered so it already points at word 1 during FETCH1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= FETCH0;
      word0     <= 32'h0;
      word1     <= 32'h0;
      udi_addr  <= 1'b0;
      udi_valid <= 1'b0;
    end else begin
      case (state)
        FETCH0: begin
          word0    <= udi_data;
          udi_addr <= 1'b1;
          state    <= FETCH1;
        end
        FETCH1: begin
          word1    <= udi_data;
          udi_addr <= 1'b0;
          state    <= DONE;
        end
        DONE: begin
          udi_valid <= 1'b1;
        end
        default: begin
          state    <= FETCH0;
          udi_addr <= 1'b0;
        end
      endcase
    end
  end

  udi_fetch_bus #(
    .ADDR_UDI_FIRST  (ADDR_UDI_FIRST),
    .ADDR_UDI_LAST   (ADDR_UDI_LAST),
    .ADDR_UDI_STATUS (ADDR_UDI_STATUS),
    .ADDR_UDI_LOCK   (ADDR_UDI_LOCK)
  ) u_bus (
    .clk              (clk),
    .reset_n          (reset_n),
    .fw_app_mode      (fw_app_mode),
    .cs               (cs),
    .we               (we),
    .address          (address),
    .udi_valid        (udi_valid),
    .word0            (word0),
    .word1            (word1),
    .read_data        (read_data),
    .ready            (ready),
    .access_violation (access_violation),
    .locked           (locked)
  );

endmodule

// File: tb/tb_udi_fetch.sv
// Directed bench for udi_fetch with a two-word ROM model.
module tb_udi_fetch;

  localparam logic [31:0] ROM_W0 = 32'h00010203;
  localparam logic [31:0] ROM_W1 = 32'h04050607;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fw_app_mode;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        udi_addr;
  logic [31:0] udi_data;
  logic        udi_valid;
  logic        access_violation;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign udi_data = udi_addr ? ROM_W1 : ROM_W0;

  udi_fetch dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fw_app_mode      (fw_app_mode),
    .cs               (cs),
    .we               (we),
    .address          (address),
    .write_data       (write_data),
    .read_data        (read_data),
    .ready            (ready),
    .udi_addr         (udi_addr),
    .udi_data         (udi_data),
    .udi_valid        (udi_valid),
    .access_violation (access_violation)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; cs = 1'b0; we = 1'b0; address = 8'h0; write_data = 32'h0;
    tick(); tick();
  endtask

  // Release reset and wait for the third edge, after which udi_valid is set.
  task automatic reset_and_fetch();
    apply_reset();
    reset_n = 1'b1;
    tick(); tick(); tick();
  endtask

  // One-cycle bus access; on return the ready cycle is visible.
  task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d);
    cs = 1'b1; we = w; address = a; write_data = d;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    fw_app_mode = 1'b0;
    apply_reset();
    checks++; if (udi_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", udi_valid); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", ready); end
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", read_data); end
    checks++; if (access_violation !== 1'b0) begin errors++; $display("FAIL rst_av: got %0b want 0", access_violation); end
    checks++; if (udi_addr !== 1'b0) begin errors++; $display("FAIL rst_udi_addr: got %0b want 0", udi_addr); end
  endtask

  task automatic test_fetch();
    fw_app_mode = 1'b0;
    apply_reset();
    reset_n = 1'b1;
    tick();
    checks++; if (udi_addr !== 1'b1) begin errors++; $display("FAIL fetch_addr1: got %0b want 1", udi_addr); end
    checks++; if (udi_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_e1: got %0b want 0", udi_valid); end
    tick();
    checks++; if (udi_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_e2: got %0b want 0", udi_valid); end
    checks++; if (udi_addr !== 1'b0) begin errors++; $display("FAIL fetch_addr_done: got %0b want 0", udi_addr); end
    tick();
    checks++; if (udi_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid_e3: got %0b want 1", udi_valid); end
    access(1'b0, 8'h30, 32'h0);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rd30_ready: got %0b want 1", ready); end
    checks++; if (read_data !== ROM_W0) begin errors++; $display("FAIL rd30_data: got %h want %h", read_data, ROM_W0); end
    checks++; if (access_violation !== 1'b0) begin errors++; $display("FAIL rd30_av: got %0b want 0", access_violation); end
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_pulse: got %0b want 0", ready); end
    checks++; if (read_data !== ROM_W0) begin errors++; $display("FAIL rdata_hold: got %h want %h", read_data, ROM_W0); end
    access(1'b0, 8'h31, 32'h0);
    checks++; if (read_data !== ROM_W1) begin errors++; $display("FAIL rd31_data: got %h want %h", read_data, ROM_W1); end
    access(1'b0, 8'h20, 32'h0);
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL rd_unmapped: got %h want 0", read_data); end
    access(1'b0, 8'h33, 32'h0);
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL rd_lockreg: got %h want 0", read_data); end
    checks++; if (access_violation !== 1'b0) begin errors++; $display("FAIL rd_lockreg_av: got %0b want 0", access_violation); end
    access(1'b1, 8'h30, 32'hFFFFFFFF);
    access(1'b0, 8'h30, 32'h0);
    checks++; if (read_data !== ROM_W0) begin errors++; $display("FAIL wr30_ignored: got %h want %h", read_data, ROM_W0); end
  endtask

  task automatic test_early_access();
    fw_app_mode = 1'b0;
    apply_reset();
    reset_n = 1'b1;
    access(1'b0, 8'h30, 32'h0);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL early_ready: got %0b want 1", ready); end
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL early_data: got %h want 0", read_data); end
    checks++; if (access_violation !== 1'b0) begin errors++; $display("FAIL early_av: got %0b want 0", access_violation); end
    // word0 is captured now but udi_valid is still low
    access(1'b0, 8'h30, 32'h0);
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL early2_data: got %h want 0", read_data); end
    access(1'b0, 8'h32, 32'h0);
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL early_status: got %h want 0", read_data); end
    tick();
    checks++; if (udi_valid !== 1'b1) begin errors++; $display("FAIL early_no_stall: got %0b want 1", udi_valid); end
  endtask

  task automatic test_app_mode();
    reset_and_fetch();
    fw_app_mode = 1'b1;
    access(1'b0, 8'h31, 32'h0);
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL app_rd31: got %h want 0", read_data); end
    checks++; if (access_violation !== 1'b1) begin errors++; $display("FAIL app_rd31_av: got %0b want 1", access_violation); end
    tick();
    checks++; if (access_violation !== 1'b0) begin errors++; $display("FAIL app_av_pulse: got %0b want 0", access_violation); end
    access(1'b0, 8'h32, 32'h0);
    checks++; if (read_data !== 32'h1) begin errors++; $display("FAIL app_status: got %h want 1", read_data); end
    checks++; if (access_violation !== 1'b0) begin errors++; $display("FAIL app_status_av: got %0b want 0", access_violation); end
    fw_app_mode = 1'b0;
  endtask

  task automatic test_lock();
    reset_and_fetch();
    fw_app_mode = 1'b0;
    access(1'b1, 8'h33, 32'hDEADBEEF);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL lock_ready: got %0b want 1", ready); end
    checks++; if (access_violation !== 1'b0) begin errors++; $display("FAIL lock_av: got %0b want 0", access_violation); end
    access(1'b0, 8'h32, 32'h0);
    checks++; if (read_data !== 32'h3) begin errors++; $display("FAIL lock_status: got %h want 3", read_data); end
    access(1'b0, 8'h30, 32'h0);
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL lock_rd30: got %h want 0", read_data); end
    checks++; if (access_violation !== 1'b1) begin errors++; $display("FAIL lock_rd30_av: got %0b want 1", access_violation); end
    // application-mode lock attempt is refused
    reset_and_fetch();
    fw_app_mode = 1'b1;
    access(1'b1, 8'h33, 32'h0);
    checks++; if (access_violation !== 1'b1) begin errors++; $display("FAIL applock_av: got %0b want 1", access_violation); end
    access(1'b0, 8'h32, 32'h0);
    checks++; if (read_data !== 32'h1) begin errors++; $display("FAIL applock_status: got %h want 1", read_data); end
    fw_app_mode = 1'b0;
    access(1'b0, 8'h31, 32'h0);
    checks++; if (read_data !== ROM_W1) begin errors++; $display("FAIL applock_rd31: got %h want %h", read_data, ROM_W1); end
  endtask

  task automatic test_back_to_back();
    reset_and_fetch();
    fw_app_mode = 1'b0;
    cs = 1'b1; we = 1'b0; address = 8'h30;
    tick();
    checks++; if (ready !== 1'b1 || read_data !== ROM_W0) begin errors++; $display("FAIL b2b_first: got ready=%0b data=%h want 1/%h", ready, read_data, ROM_W0); end
    address = 8'h31;
    tick();
    checks++; if (ready !== 1'b1 || read_data !== ROM_W1) begin errors++; $display("FAIL b2b_second: got ready=%0b data=%h want 1/%h", ready, read_data, ROM_W1); end
    // lock then immediately read: the lock applies to this following access
    we = 1'b1; address = 8'h33;
    tick();
    we = 1'b0; address = 8'h30;
    tick();
    cs = 1'b0;
    checks++; if (read_data !== 32'h0 || access_violation !== 1'b1) begin errors++; $display("FAIL b2b_locked: got data=%h av=%0b want 0/1", read_data, access_violation); end
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_end_ready: got %0b want 0", ready); end
  endtask

  task automatic test_reset_mid();
    fw_app_mode = 1'b0;
    apply_reset();
    reset_n = 1'b1;
    access(1'b1, 8'h33, 32'h0);
    // now in FETCH1 with locked set; abort with an access pending
    reset_n = 1'b0;
    cs = 1'b1; we = 1'b0; address = 8'h32;
    tick();
    cs = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %0b want 0", ready); end
    checks++; if (udi_addr !== 1'b0) begin errors++; $display("FAIL mid_udi_addr: got %0b want 0", udi_addr); end
    reset_n = 1'b1;
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_ready2: got %0b want 0", ready); end
    tick();
    checks++; if (udi_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_e2: got %0b want 0", udi_valid); end
    tick();
    checks++; if (udi_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_e3: got %0b want 1", udi_valid); end
    access(1'b0, 8'h32, 32'h0);
    checks++; if (read_data !== 32'h1) begin errors++; $display("FAIL mid_status: got %h want 1", read_data); end
    access(1'b0, 8'h30, 32'h0);
    checks++; if (read_data !== ROM_W0) begin errors++; $display("FAIL mid_rd30: got %h want %h", read_data, ROM_W0); end
  endtask

  initial begin
    reset_n = 1'b0; fw_app_mode = 1'b0; cs = 1'b0; we = 1'b0;
    address = 8'h0; write_data = 32'h0;
    test_reset();
    test_fetch();
    test_early_access();
    test_app_mode();
    test_lock();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
